// File: rtl/data_memory_ws_pkg.sv
// ============================================================================
// Module   : data_memory_ws_pkg
// Brief    : Shared FSM states and wait-counter sizing for data_memory_ws.
// Revision : 1.0
// ============================================================================
`default_nettype none

package data_memory_ws_pkg;

    localparam int C_WAIT_MAX = 15;
    localparam int C_CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/data_memory_array.sv
// ============================================================================
// Module   : data_memory_array
// Brief    : Byte-enabled word storage, synchronous write, asynchronous read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_memory_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [IDX_W-1:0]    raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Whole array clears on reset so post-reset reads are deterministic.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem_q[w] <= '0;
            end
        end else if (we_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/data_memory_ws.sv
// ============================================================================
// Module   : data_memory_ws
// Brief    : Wait-state data memory: IDLE -> WAIT -> DONE handshake per access.
//            Optional macro DATA_MEMORY_ERR_EN adds the err port and checking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module data_memory_ws
    import data_memory_ws_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_rd,
    input  logic                req_wr,
    input  logic [31:0]         addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                busy
`ifdef DATA_MEMORY_ERR_EN
    ,
    output logic                err
`endif
);

    localparam int C_IDX_W = $clog2(DEPTH);
    localparam int C_BE_W  = DATA_W / 8;
    localparam logic [C_CNT_W-1:0] C_WAIT_LOAD =
        C_CNT_W'((WAIT_CYCLES > C_WAIT_MAX) ? C_WAIT_MAX : WAIT_CYCLES);

    state_e              state_q, state_d;
    logic [C_CNT_W-1:0]  cnt_q, cnt_d;
    logic [C_IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [C_BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                wr_q, wr_d;
    logic                aerr_q, aerr_d;
    logic                w_addr_err;
    logic                w_mem_we;
    logic [DATA_W-1:0]   w_mem_rdata;

`ifdef DATA_MEMORY_ERR_EN
    assign w_addr_err = (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
`else
    // Bits outside the word index are deliberately ignored so addresses wrap.
    logic w_unused_addr;
    assign w_unused_addr = ^{addr[31:C_IDX_W+2], addr[1:0]};
    assign w_addr_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            aerr_q  <= aerr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rdata_d  = rdata_q;
        wr_d     = wr_q;
        aerr_d   = aerr_q;
        w_mem_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_rd || req_wr) begin
                    idx_d   = addr[C_IDX_W+1:2];
                    wdata_d = wdata;
                    be_d    = byte_en;
                    wr_d    = req_wr;
                    aerr_d  = w_addr_err;
                    cnt_d   = C_WAIT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The access commits only on leaving WAIT, so a reset here aborts it.
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    if (!aerr_q) begin
                        if (wr_q) begin
                            w_mem_we = 1'b1;
                        end else begin
                            rdata_d = w_mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    data_memory_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (C_IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (w_mem_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .be_i    (be_q),
        .raddr_i (idx_q),
        .rdata_o (w_mem_rdata)
    );

    assign rdata = rdata_q;
    assign ready = (state_q == ST_DONE);
    assign busy  = (state_q != ST_IDLE);
`ifdef DATA_MEMORY_ERR_EN
    assign err   = (state_q == ST_DONE) && aerr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_memory_ws.sv
// ============================================================================
// Module   : tb_data_memory_ws
// Brief    : Self-checking bench for data_memory_ws against a word-array model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_data_memory_ws;

    localparam int DATA_W      = 32;
    localparam int DEPTH       = 64;
    localparam int WAIT_CYCLES = 2;
`ifdef DATA_MEMORY_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd, req_wr;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  byte_en;
    logic        ready, busy;
    logic        s_rd;
    logic [31:0] s_rdata [3];
    logic        s_ready [3];
    logic        s_busy  [3];
`ifdef DATA_MEMORY_ERR_EN
    logic        err;
    logic        s_err   [3];
`endif

    always #5 clk = ~clk;

    data_memory_ws #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) u_dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .addr(addr),
        .wdata(wdata), .byte_en(byte_en), .rdata(rdata), .ready(ready), .busy(busy)
`ifdef DATA_MEMORY_ERR_EN
        , .err(err)
`endif
    );

    data_memory_ws #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .req_rd(s_rd), .req_wr(1'b0), .addr(addr),
        .wdata(wdata), .byte_en(byte_en), .rdata(s_rdata[0]), .ready(s_ready[0]), .busy(s_busy[0])
`ifdef DATA_MEMORY_ERR_EN
        , .err(s_err[0])
`endif
    );

    data_memory_ws #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst), .req_rd(s_rd), .req_wr(1'b0), .addr(addr),
        .wdata(wdata), .byte_en(byte_en), .rdata(s_rdata[1]), .ready(s_ready[1]), .busy(s_busy[1])
`ifdef DATA_MEMORY_ERR_EN
        , .err(s_err[1])
`endif
    );

    data_memory_ws #(.DATA_W(DATA_W), .DEPTH(DEPTH), .WAIT_CYCLES(15)) u_w15 (
        .clk(clk), .rst(rst), .req_rd(s_rd), .req_wr(1'b0), .addr(addr),
        .wdata(wdata), .byte_en(byte_en), .rdata(s_rdata[2]), .ready(s_ready[2]), .busy(s_busy[2])
`ifdef DATA_MEMORY_ERR_EN
        , .err(s_err[2])
`endif
    );

    logic [31:0] model [DEPTH];
    logic [31:0] model_rdata;
    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit flagged(input logic [31:0] a);
        return ERR_EN && ((a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4)));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        model_rdata = '0;
    endfunction

    // Write wins over read; a flagged access leaves everything untouched.
    function automatic void model_op(input bit rd, input bit wr, input logic [31:0] a,
                                     input logic [31:0] d, input logic [3:0] be);
        int idx;
        idx = int'((a / 4) % DEPTH);
        if (flagged(a)) return;
        if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
        end else if (rd) begin
            model_rdata = model[idx];
        end
    endfunction

    task automatic do_op(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be, input string tag);
        int lat;
        bit busy_ok;
        @(negedge clk);
        req_rd = rd; req_wr = wr; addr = a; wdata = d; byte_en = be;
        lat = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!busy) busy_ok = 1'b0;
        end while (!ready && lat < 40);
        req_rd = 1'b0; req_wr = 1'b0;
        model_op(rd, wr, a, d, be);
        check({tag, " latency"}, 32'(lat), 32'(WAIT_CYCLES + 2));
        check({tag, " busy"}, {31'b0, busy_ok}, 32'd1);
        check({tag, " rdata"}, rdata, model_rdata);
`ifdef DATA_MEMORY_ERR_EN
        check({tag, " err"}, {31'b0, err}, {31'b0, flagged(a)});
`endif
        @(posedge clk); #1;
        check({tag, " ready pulse"}, {31'b0, ready}, 32'd0);
    endtask

    initial begin
        logic [31:0] prev;
        bit          ready_seen;
        int          lat_s [3];
        bit          bz_s  [3];
        bit          r_rd, r_wr;

        rst = 1'b0; req_rd = 1'b0; req_wr = 1'b0; s_rd = 1'b0;
        addr = '0; wdata = '0; byte_en = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset rdata", rdata, 32'h0);
        check("reset ready", {31'b0, ready}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        rst = 1'b1;

        do_op(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr 0x10");
        do_op(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "rd 0x10");
        check("full word", rdata, 32'hDEADBEEF);

        do_op(1'b0, 1'b1, 32'h10, 32'h11223344, 4'h3, "partial wr");
        do_op(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "partial rd");
        check("byte enable", rdata, 32'hDEAD3344);

        prev = rdata;
        do_op(1'b1, 1'b1, 32'h20, 32'h5, 4'hF, "rd+wr");
        check("rd+wr rdata held", rdata, prev);
        do_op(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, "rd 0x20");
        check("word 8", rdata, 32'h5);

        do_op(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, "be zero");
        do_op(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "rd be zero");
        check("be zero unchanged", rdata, 32'hDEAD3344);

        do_op(1'b0, 1'b1, 32'h4, 32'hCAFEF00D, 4'hF, "wr word1");
        prev = rdata;
        do_op(1'b1, 1'b0, 32'h104, 32'h0, 4'h0, "rd 0x104");
        check("wrap or err", rdata, ERR_EN ? prev : 32'hCAFEF00D);

        // Abort a pending write by resetting in the middle of its wait.
        @(negedge clk);
        req_wr = 1'b1; addr = 32'h4; wdata = 32'hFFFFFFFF; byte_en = 4'hF;
        @(posedge clk); #1;
        ready_seen = ready;
        @(negedge clk);
        rst = 1'b0; req_wr = 1'b0;
        @(posedge clk); #1;
        ready_seen = ready_seen | ready;
        @(negedge clk);
        rst = 1'b1;
        model_clear();
        check("abort ready", {31'b0, ready_seen}, 32'd0);
        check("abort busy", {31'b0, busy}, 32'd0);
        do_op(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, "rd after abort");
        check("abort no commit", rdata, 32'h0);

        @(negedge clk);
        addr = 32'h0; s_rd = 1'b1;
        for (int i = 0; i < 3; i++) begin lat_s[i] = 0; bz_s[i] = 1'b1; end
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) s_rd = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (lat_s[i] == 0) begin
                    if (!s_busy[i]) bz_s[i] = 1'b0;
                    if (s_ready[i]) lat_s[i] = cyc;
                end
            end
        end
        check("latency W0", 32'(lat_s[0]), 32'd2);
        check("latency W1", 32'(lat_s[1]), 32'd3);
        check("latency W15", 32'(lat_s[2]), 32'd17);
        for (int i = 0; i < 3; i++) begin
            check("sweep busy", {31'b0, bz_s[i]}, 32'd1);
            check("sweep rdata", s_rdata[i], 32'h0);
        end

        for (int n = 0; n < 60; n++) begin
            r_rd = 1'($urandom_range(0, 1));
            r_wr = 1'($urandom_range(0, 1));
            if (!r_rd && !r_wr) r_rd = 1'b1;
            do_op(r_rd, r_wr, 32'($urandom_range(0, 511)), $urandom, 4'($urandom_range(0, 15)), "random");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/data_memory_ws.md
DATA_MEMORY_WS -- requirements
Module: data_memory_ws

Interface
REQ-001 Parameter DATA_W, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 64: number of words; SHALL be a power of two, at least 2.
REQ-003 Parameter WAIT_CYCLES, default 2: added access latency in cycles; legal range 0..15.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 req_rd  in  1  read request, held by the requester until ready.
REQ-007 req_wr  in  1  write request, held by the requester until ready.
REQ-008 addr  in  32  byte address; word index = addr[log2(DEPTH)+1:2].
REQ-009 wdata  in  DATA_W  write data.
REQ-010 byte_en  in  DATA_W/8  per-byte write enable.
REQ-011 rdata  out  DATA_W  read data, registered.
REQ-012 ready  out  1  one-cycle completion pulse.
REQ-013 busy  out  1  high while a request is in flight.
REQ-014 err  out  1  address error flag; present only with DATA_MEMORY_ERR_EN.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and DONE, with DONE lasting exactly one cycle.
REQ-016 In IDLE with req_rd or req_wr high, the block SHALL capture addr, wdata, byte_en and the operation, load the wait counter with WAIT_CYCLES, and enter WAIT.
REQ-017 In WAIT the counter SHALL decrement each cycle; at zero the access SHALL execute and the FSM SHALL enter DONE.
REQ-018 With WAIT_CYCLES=0, WAIT SHALL last one cycle, so ready asserts 2 cycles after acceptance; generally the latency SHALL be WAIT_CYCLES+2 cycles.
REQ-019 ready SHALL be high only in DONE; busy SHALL be high in WAIT and DONE.
REQ-020 DONE SHALL return to IDLE; a request still held in that IDLE cycle SHALL be accepted as new.
REQ-021 A write SHALL update only the bytes whose byte_en bit is 1; byte_en = 0 SHALL complete with no change to memory.
REQ-022 A read SHALL load rdata with the addressed word in DONE; rdata SHALL hold that value until the next read completes, and writes SHALL NOT alter rdata.
REQ-023 When req_rd and req_wr are both high at acceptance, the write SHALL take priority and no read SHALL occur.
REQ-024 Request changes while busy SHALL be ignored, with no re-capture.
REQ-025 Without DATA_MEMORY_ERR_EN, the address bits above the index and addr[1:0] SHALL be ignored, so out-of-range addresses wrap.

Reset
REQ-026 With rst low at a clock edge, the FSM SHALL go to IDLE, the counter, rdata, ready, busy and err SHALL go to 0, and all DEPTH words SHALL clear to 0.
REQ-027 Reset during WAIT SHALL abort the access; a pending write SHALL NOT be committed and ready SHALL NOT pulse.

Configuration
REQ-028 With macro DATA_MEMORY_ERR_EN defined, the err port SHALL exist and an access SHALL be flagged when addr[1:0] != 0 or addr >= DEPTH*4.
REQ-029 A flagged access SHALL still complete with a ready pulse and err high in DONE only; the write SHALL be suppressed and rdata SHALL be left unchanged.
REQ-030 Without DATA_MEMORY_ERR_EN, the err port SHALL be absent and addressing SHALL follow REQ-025.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the WAIT_CYCLES maximum (15) and the counter width (4).
REQ-032 The byte-enabled storage array SHALL be a sub-module named data_memory_array, with a synchronous write port and an asynchronous read port.

Verification
REQ-033 Reset, then write addr 0x10, wdata 0xDEADBEEF, byte_en 0xF, then read 0x10 -> rdata 0xDEADBEEF with ready exactly WAIT_CYCLES+2 cycles after acceptance.
REQ-034 Over 0xDEADBEEF, write 0x11223344 with byte_en 0x3, then read -> rdata 0xDEAD3344.
REQ-035 req_rd and req_wr both high, wdata 0x5, addr 0x20 -> word 8 = 0x5 and rdata unchanged.
REQ-036 Assert rst low during WAIT of a write of 0xFFFFFFFF to 0x4, then read 0x4 -> 0x0 and no ready during the reset.
REQ-037 Read 0x104 with DEPTH=64 -> without the macro, returns word 1 (wrap); with DATA_MEMORY_ERR_EN, err=1 in DONE and rdata unchanged.
REQ-038 Sweep WAIT_CYCLES over 0, 1 and 15 -> measured latency 2, 3 and 17 cycles; busy high throughout each access.
